prim_core_p: RTL and testbench
==============================

# prim_core_p

Parametrised successor to the single-cycle primitive device: a small programmable datapath core with a writable instruction memory, a register file, an ALU, conditional and unconditional relative branches, and a halt state. It adds DATA_W/IMEM_DEPTH/IN_CH generalisation, handshaked multi-channel input with stall, a one-entry buffered output port, and a halt state. It sits between board I/O (switches, HEX display) and a host loader that fills program memory.

## Interface
- DATA_W, 32: datapath and register width (≥8).
- NREG, 32: implemented registers (≤32).
- IMEM_DEPTH, 256: instruction words; IMEM_AW = $clog2(IMEM_DEPTH).
- IN_CH, 4: input channels (1..32).
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  global execute enable.
- imem_we_i  in  1  program-memory write strobe.
- imem_addr_i  in  IMEM_AW  program write address.
- imem_wdata_i  in  32  program write data.
- in_data_i  in  IN_CH*DATA_W  channel c at [c*DATA_W +: DATA_W].
- in_valid_i  in  IN_CH  per-channel valid.
- in_ready_o  out  IN_CH  per-channel ready.
- out_data_o  out  DATA_W  output buffer data.
- out_valid_o  out  1  output buffer full.
- out_ready_i  in  1  output sink accepts.
- hex_o  out  DATA_W  last value written to the register file.
- pc_o  out  IMEM_AW  current PC (word index).
- halted_o  out  1  core in HALT.

## Operation
- Instruction: [31] J, [30] B, [29:28] WS, [27:23] OP, [22:18] RA1, [17:13] RA2, [12:5] C8, [4:0] WA. CONST = sign-extend(C8) to DATA_W.
- WS: 0 no write; 1 IN; 2 RF[WA]←CONST; 3 RF[WA]←ALU result (A=RF[RA1], B=RF[RA2]).
- WS=0 with J=B=0: OP=5'b00001 OUT, OP=5'b00010 HALT, other OP NOP.
- ALU OP: ADD 00000, SUB 01000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111; compare BEQ 11000, BNE 11001, BLT 11100, BGE 11101, BLTU 11110, BGEU 11111 (flag=compare, result=0). Non-compare ops: flag=0. Shift amount = B[$clog2(DATA_W)-1:0]. Arithmetic mod 2^DATA_W.
- Next PC: J | (B & flag) → PC + CONST (mod IMEM_DEPTH); else PC+1; wraps at IMEM_DEPTH-1 → 0.
- RA/WA ≥ NREG: reads 0, writes dropped (hex_o unchanged).
- IN: channel c = RA1; in_ready_o[c]=1 while executing in RUN with en_i=1; retire on in_valid_i[c]; else stall. c ≥ IN_CH: writes 0, no stall.
- OUT: loads buffer with RF[RA1] and retires when out_valid_o=0 or out_ready_i=1; else stall. Buffer clears on out_ready_i when not reloaded.
- FSM: RUN (retire or stall per above), HALT (entered when HALT retires; PC frozen; exits only via rst_i). Output buffer drains in any state and regardless of en_i.
- en_i=0: no retire, no RF/PC write, in_ready_o=0.

## Timing
- Reset: PC=0, RUN, out_valid_o=0, out_data_o=0, hex_o=0, halted_o=0, registers=0; IMEM contents preserved.
- Fetch/read combinational; RF, PC, hex_o and buffer update on the retire edge: one instruction per cycle absent stalls.
- IMEM write to the address being fetched: current cycle executes old word.
- Write and read of the same register in one instruction: read returns old value.
- Reset mid-stall: handshake dropped, in_ready_o=0 immediately.

## Structure
- Package prim_core_pkg: OP codes, WS enum, field bit positions, state enum.
- Sub-module prim_alu (DATA_W-parametrised, OP → result, flag); RF, IMEM, FSM, and output buffer live in prim_core_p.

## Test plan
- Load {WS=2 C8=5 WA=1; WS=2 C8=-3 WA=2; WS=3 ADD RA1=1 RA2=2 WA=3; HALT} → hex_o 5, 0xFFFFFFFD, 2; halted_o=1, pc_o=3 held.
- Countdown loop with BNE back-branch (C8=-2) from 3 to 0 → exactly 3 taken branches, then falls through.
- IN on channel 2, in_valid_i[2] raised after 4 cycles → in_ready_o[2]=1 for 5 cycles, pc_o frozen 4 cycles, value written.
- Two back-to-back OUTs with out_ready_i=0 → first loads, second stalls until ready pulse; out_data_o sequence correct.
- J with C8=-1 at PC=0 → pc_o wraps to IMEM_DEPTH-1.
- rst_i asserted during OUT stall → out_valid_o=0, pc_o=0 asynchronously; program re-runs from IMEM unchanged.

Source files
------------

// File: rtl/prim_core_pkg.sv
// rtl/prim_core_pkg.sv - instruction fields, opcodes and state encoding for prim_core_p
package prim_core_pkg;

    typedef enum logic [1:0] {
        WS_NONE  = 2'd0,
        WS_IN    = 2'd1,
        WS_CONST = 2'd2,
        WS_ALU   = 2'd3
    } ws_e;

    // Field order fixes the bit positions: j[31] b[30] ws[29:28] op[27:23] ra1[22:18] ra2[17:13] c8[12:5] wa[4:0]
    typedef struct packed {
        logic       j;
        logic       b;
        ws_e        ws;
        logic [4:0] op;
        logic [4:0] ra1;
        logic [4:0] ra2;
        logic [7:0] c8;
        logic [4:0] wa;
    } instr_t;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b01000;
    localparam logic [4:0] OP_SLL  = 5'b00001;
    localparam logic [4:0] OP_SLT  = 5'b00010;
    localparam logic [4:0] OP_SLTU = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SRA  = 5'b01101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_AND  = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b11000;
    localparam logic [4:0] OP_BNE  = 5'b11001;
    localparam logic [4:0] OP_BLT  = 5'b11100;
    localparam logic [4:0] OP_BGE  = 5'b11101;
    localparam logic [4:0] OP_BLTU = 5'b11110;
    localparam logic [4:0] OP_BGEU = 5'b11111;

    // Control opcodes, only meaningful when ws=WS_NONE and j=b=0
    localparam logic [4:0] OP_OUT  = 5'b00001;
    localparam logic [4:0] OP_HALT = 5'b00010;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/prim_alu.sv
// rtl/prim_alu.sv - combinational ALU producing a result and a compare flag
module prim_alu
    import prim_core_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [4:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              flag
);

    localparam int SHW = $clog2(DATA_W);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        flag   = 1'b0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLL:  result = a << shamt;
            OP_SLT:  result = DATA_W'($signed(a) < $signed(b));
            OP_SLTU: result = DATA_W'(a < b);
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> shamt);
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_BEQ:  flag = (a == b);
            OP_BNE:  flag = (a != b);
            OP_BLT:  flag = ($signed(a) < $signed(b));
            OP_BGE:  flag = ($signed(a) >= $signed(b));
            OP_BLTU: flag = (a < b);
            OP_BGEU: flag = (a >= b);
            default: ;
        endcase
    end

endmodule

// File: rtl/prim_core_p.sv
// rtl/prim_core_p.sv - programmable datapath core with IMEM, register file, handshaked I/O and halt
module prim_core_p
    import prim_core_pkg::*;
#(
    parameter int  DATA_W     = 32,
    parameter int  NREG       = 32,
    parameter int  IMEM_DEPTH = 256,
    parameter int  IN_CH      = 4,
    localparam int IMEM_AW    = $clog2(IMEM_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      imem_we_i,
    input  logic [IMEM_AW-1:0]        imem_addr_i,
    input  logic [31:0]               imem_wdata_i,
    input  logic [IN_CH*DATA_W-1:0]   in_data_i,
    input  logic [IN_CH-1:0]          in_valid_i,
    output logic [IN_CH-1:0]          in_ready_o,
    output logic [DATA_W-1:0]         out_data_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_W-1:0]         hex_o,
    output logic [IMEM_AW-1:0]        pc_o,
    output logic                      halted_o
);

    localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    logic [31:0]        imem [IMEM_DEPTH];
    logic [DATA_W-1:0]  rf   [NREG];
    logic [IMEM_AW-1:0] pc;
    state_e             state;

    instr_t             ins;
    logic [DATA_W-1:0]  rd_a, rd_b, cst, alu_res, in_val, wdata;
    logic               alu_flag;
    logic               exec_ok, is_ctl, is_out, is_halt, is_in, in_hit, in_valid_sel;
    logic               stall, retire, do_write;
    logic [IMEM_AW-1:0] pc_next;
    int                 pc_sum;

    assign ins  = instr_t'(imem[pc]);
    assign pc_o = pc;

    assign rd_a = (int'(ins.ra1) < NREG) ? rf[ins.ra1[RIDX_W-1:0]] : '0;
    assign rd_b = (int'(ins.ra2) < NREG) ? rf[ins.ra2[RIDX_W-1:0]] : '0;
    assign cst  = DATA_W'($signed(ins.c8));

    prim_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (ins.op),
        .a      (rd_a),
        .b      (rd_b),
        .result (alu_res),
        .flag   (alu_flag)
    );

    assign exec_ok = (state == ST_RUN) && en_i && !rst_i;
    assign is_ctl  = (ins.ws == WS_NONE) && !ins.j && !ins.b;
    assign is_out  = is_ctl && (ins.op == OP_OUT);
    assign is_halt = is_ctl && (ins.op == OP_HALT);
    assign is_in   = (ins.ws == WS_IN);
    assign in_hit  = int'(ins.ra1) < IN_CH;

    // Channel select doubles as the ready decode; out-of-range channels read zero
    always_comb begin
        in_val       = '0;
        in_valid_sel = 1'b0;
        in_ready_o   = '0;
        for (int c = 0; c < IN_CH; c++) begin
            if (int'(ins.ra1) == c) begin
                in_val        = in_data_i[c*DATA_W +: DATA_W];
                in_valid_sel  = in_valid_i[c];
                in_ready_o[c] = exec_ok && is_in;
            end
        end
    end

    assign stall    = (is_in && in_hit && !in_valid_sel) ||
                      (is_out && out_valid_o && !out_ready_i);
    assign retire   = exec_ok && !stall;
    assign do_write = retire && (ins.ws != WS_NONE) && (int'(ins.wa) < NREG);

    always_comb begin
        case (ins.ws)
            WS_IN:    wdata = in_val;
            WS_CONST: wdata = cst;
            WS_ALU:   wdata = alu_res;
            default:  wdata = '0;
        endcase
    end

    // Relative target wraps modulo the memory depth in both directions
    always_comb begin
        pc_sum = int'(pc) + 1;
        if (ins.j || (ins.b && alu_flag)) begin
            pc_sum = int'(pc) + int'($signed(ins.c8));
        end
        pc_sum = pc_sum % IMEM_DEPTH;
        if (pc_sum < 0) begin
            pc_sum = pc_sum + IMEM_DEPTH;
        end
        pc_next = IMEM_AW'(pc_sum);
    end

    always_ff @(posedge clk_i) begin
        if (imem_we_i) begin
            imem[imem_addr_i] <= imem_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_RUN;
            halted_o    <= 1'b0;
            pc          <= '0;
            hex_o       <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (retire && is_out) begin
                out_valid_o <= 1'b1;
                out_data_o  <= rd_a;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
            if (do_write) begin
                rf[ins.wa[RIDX_W-1:0]] <= wdata;
                hex_o                  <= wdata;
            end
            if (retire) begin
                if (is_halt) begin
                    state    <= ST_HALT;
                    halted_o <= 1'b1;
                end else begin
                    pc <= pc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_prim_core_p.sv
// tb/tb_prim_core_p.sv - self-checking bench for prim_core_p
module tb_prim_core_p;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         en_i;
    logic         imem_we_i;
    logic [7:0]   imem_addr_i;
    logic [31:0]  imem_wdata_i;
    logic [127:0] in_data_i;
    logic [3:0]   in_valid_i;
    logic [3:0]   in_ready_o;
    logic [31:0]  out_data_o;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [31:0]  hex_o;
    logic [7:0]   pc_o;
    logic         halted_o;

    prim_core_p #(.DATA_W(32), .NREG(32), .IMEM_DEPTH(256), .IN_CH(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .imem_we_i    (imem_we_i),
        .imem_addr_i  (imem_addr_i),
        .imem_wdata_i (imem_wdata_i),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .hex_o        (hex_o),
        .pc_o         (pc_o),
        .halted_o     (halted_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb [$];
    logic [31:0] prog [16];
    int plen;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        flag;
    } vec_t;
    vec_t vt [16];

    function automatic logic [31:0] enc(logic j, logic b, logic [1:0] ws, logic [4:0] op,
                                        logic [4:0] ra1, logic [4:0] ra2, logic [7:0] c8, logic [4:0] wa);
        return {j, b, ws, op, ra1, ra2, c8, wa};
    endfunction
    function automatic logic [31:0] ldc(logic [4:0] wa, logic [7:0] c8);
        return enc(1'b0, 1'b0, 2'd2, 5'd0, 5'd0, 5'd0, c8, wa);
    endfunction
    function automatic logic [31:0] alu(logic [4:0] op, logic [4:0] ra1, logic [4:0] ra2, logic [4:0] wa);
        return enc(1'b0, 1'b0, 2'd3, op, ra1, ra2, 8'd0, wa);
    endfunction
    function automatic logic [31:0] inp(logic [4:0] ch, logic [4:0] wa);
        return enc(1'b0, 1'b0, 2'd1, 5'd0, ch, 5'd0, 8'd0, wa);
    endfunction
    function automatic logic [31:0] outp(logic [4:0] ra);
        return enc(1'b0, 1'b0, 2'd0, 5'b00001, ra, 5'd0, 8'd0, 5'd0);
    endfunction
    function automatic logic [31:0] halt_i();
        return enc(1'b0, 1'b0, 2'd0, 5'b00010, 5'd0, 5'd0, 8'd0, 5'd0);
    endfunction
    function automatic logic [31:0] br(logic [4:0] op, logic [4:0] ra1, logic [4:0] ra2, logic [7:0] c8);
        return enc(1'b0, 1'b1, 2'd0, op, ra1, ra2, c8, 5'd0);
    endfunction
    function automatic logic [31:0] jmp(logic [7:0] c8);
        return enc(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, c8, 5'd0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr_imem(input int addr, input logic [31:0] data);
        @(negedge clk_i);
        imem_we_i    = 1'b1;
        imem_addr_i  = 8'(addr);
        imem_wdata_i = data;
        @(negedge clk_i);
        imem_we_i    = 1'b0;
    endtask

    task automatic load_and_start();
        rst_i = 1'b1;
        for (int i = 0; i < plen; i++) begin
            wr_imem(i, prog[i]);
        end
        rst_i = 1'b0;
    endtask

    task automatic sb_pop(input string name);
        logic [31:0] exp;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected output %0h, scoreboard empty", name, out_data_o);
        end else begin
            exp = sb.pop_front();
            chk(name, out_data_o, exp);
        end
    endtask

    task automatic wait_out(input string name, input int bound);
        int k;
        k = 0;
        while (!(out_valid_o && out_ready_i) && k < bound) begin
            @(negedge clk_i);
            k++;
        end
        if (out_valid_o && out_ready_i) sb_pop(name);
        else chk({name, " timeout"}, 32'(out_valid_o), 32'd1);
    endtask

    task automatic wait_halt(input string name, input int bound);
        int k;
        k = 0;
        while (!halted_o && k < bound) begin
            @(negedge clk_i);
            k++;
        end
        chk(name, 32'(halted_o), 32'd1);
    endtask

    initial begin
        int taken, rdy_cnt, stall_edges;
        logic [7:0] prev_pc;

        vt[0]  = '{5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
        vt[1]  = '{5'b01000, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0};
        vt[2]  = '{5'b00001, 32'h00000001, 32'h00000023, 32'h00000008, 1'b0};
        vt[3]  = '{5'b00010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
        vt[4]  = '{5'b00011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        vt[5]  = '{5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
        vt[6]  = '{5'b00101, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0};
        vt[7]  = '{5'b01101, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0};
        vt[8]  = '{5'b00110, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0};
        vt[9]  = '{5'b00111, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0};
        vt[10] = '{5'b11000, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1};
        vt[11] = '{5'b11001, 32'h00000007, 32'h00000007, 32'h00000000, 1'b0};
        vt[12] = '{5'b11100, 32'hFFFFFFFE, 32'h00000001, 32'h00000000, 1'b1};
        vt[13] = '{5'b11101, 32'hFFFFFFFE, 32'h00000001, 32'h00000000, 1'b0};
        vt[14] = '{5'b11110, 32'hFFFFFFFE, 32'h00000001, 32'h00000000, 1'b0};
        vt[15] = '{5'b11111, 32'hFFFFFFFE, 32'h00000001, 32'h00000000, 1'b1};

        rst_i = 1'b1; en_i = 1'b1; imem_we_i = 1'b0; imem_addr_i = '0; imem_wdata_i = '0;
        in_data_i = '0; in_valid_i = '0; out_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst pc", 32'(pc_o), 32'd0);
        chk("rst halted", 32'(halted_o), 32'd0);
        chk("rst out_valid", 32'(out_valid_o), 32'd0);
        chk("rst out_data", out_data_o, 32'd0);
        chk("rst hex", hex_o, 32'd0);
        chk("rst in_ready", 32'(in_ready_o), 32'd0);

        // Constant loads and add, with execution held off by en_i first
        prog[0] = ldc(5'd1, 8'd5); prog[1] = ldc(5'd2, 8'hFD);
        prog[2] = alu(5'b00000, 5'd1, 5'd2, 5'd3); prog[3] = halt_i(); plen = 4;
        en_i = 1'b0;
        load_and_start();
        repeat (3) @(negedge clk_i);
        chk("en0 pc", 32'(pc_o), 32'd0);
        chk("en0 hex", hex_o, 32'd0);
        en_i = 1'b1;
        @(negedge clk_i); chk("A hex c5", hex_o, 32'd5);
        @(negedge clk_i); chk("A hex cm3", hex_o, 32'hFFFFFFFD);
        @(negedge clk_i); chk("A hex add", hex_o, 32'd2);
        @(negedge clk_i); chk("A halted", 32'(halted_o), 32'd1); chk("A pc", 32'(pc_o), 32'd3);
        repeat (3) @(negedge clk_i);
        chk("A pc held", 32'(pc_o), 32'd3); chk("A still halted", 32'(halted_o), 32'd1);

        // Backward jump from PC 0 wraps to the top of memory
        rst_i = 1'b1;
        wr_imem(255, halt_i());
        prog[0] = jmp(8'hFF); plen = 1;
        load_and_start();
        @(negedge clk_i); chk("wrap pc", 32'(pc_o), 32'd255);
        @(negedge clk_i); chk("wrap halted", 32'(halted_o), 32'd1); chk("wrap pc held", 32'(pc_o), 32'd255);

        // Countdown: BNE at 5 back to 3 while r1 != 0
        prog[0] = ldc(5'd1, 8'd3); prog[1] = ldc(5'd2, 8'd1); prog[2] = jmp(8'd3);
        prog[3] = alu(5'b01000, 5'd1, 5'd2, 5'd1); prog[4] = 32'h0;
        prog[5] = br(5'b11001, 5'd1, 5'd0, 8'hFE); prog[6] = halt_i(); plen = 7;
        load_and_start();
        taken = 0; prev_pc = pc_o;
        for (int k = 0; k < 60 && !halted_o; k++) begin
            @(negedge clk_i);
            if (prev_pc == 8'd5 && pc_o == 8'd3) taken++;
            prev_pc = pc_o;
        end
        chk("loop halted", 32'(halted_o), 32'd1);
        chk("loop taken", 32'(taken), 32'd3);
        chk("loop pc", 32'(pc_o), 32'd6);
        chk("loop hex", hex_o, 32'd0);

        // IN on channel 2 with valid arriving four cycles late
        prog[0] = inp(5'd2, 5'd7); prog[1] = halt_i(); plen = 2;
        in_data_i = {32'h0, 32'hCAFEBABE, 32'h11111111, 32'h22222222};
        in_valid_i = 4'b1011;
        load_and_start();
        rdy_cnt = 0; stall_edges = 0; prev_pc = 8'hFF;
        for (int k = 0; k < 7; k++) begin
            #1;
            if (in_ready_o == 4'b0100) rdy_cnt++;
            if (prev_pc == 8'd0 && pc_o == 8'd0) stall_edges++;
            prev_pc = pc_o;
            if (k == 4) in_valid_i[2] = 1'b1;
            @(negedge clk_i);
        end
        chk("in ready cycles", 32'(rdy_cnt), 32'd5);
        chk("in stall edges", 32'(stall_edges), 32'd4);
        chk("in value", hex_o, 32'hCAFEBABE);
        chk("in halted", 32'(halted_o), 32'd1);
        in_valid_i = '0;

        // Back-to-back OUTs against a stalled sink
        prog[0] = ldc(5'd1, 8'h11); prog[1] = ldc(5'd2, 8'h22); prog[2] = outp(5'd1);
        prog[3] = outp(5'd2); prog[4] = halt_i(); plen = 5;
        out_ready_i = 1'b0;
        sb.delete(); sb.push_back(32'h11); sb.push_back(32'h22);
        load_and_start();
        for (int k = 0; k < 10 && !out_valid_o; k++) @(negedge clk_i);
        repeat (3) @(negedge clk_i);
        chk("out stall pc", 32'(pc_o), 32'd3);
        chk("out stall valid", 32'(out_valid_o), 32'd1);
        out_ready_i = 1'b1; #1;
        sb_pop("out first");
        @(negedge clk_i); out_ready_i = 1'b0;
        chk("out second valid", 32'(out_valid_o), 32'd1);
        repeat (2) @(negedge clk_i);
        chk("out halted", 32'(halted_o), 32'd1);
        out_ready_i = 1'b1; #1;
        sb_pop("out second");
        @(negedge clk_i);
        chk("out drained", 32'(out_valid_o), 32'd0);
        chk("out sb empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of an OUT stall, program must survive
        out_ready_i = 1'b0;
        rst_i = 1'b1; @(negedge clk_i); rst_i = 1'b0;
        for (int k = 0; k < 10 && !out_valid_o; k++) @(negedge clk_i);
        repeat (2) @(negedge clk_i);
        chk("pre-rst pc", 32'(pc_o), 32'd3);
        #2 rst_i = 1'b1; #1;
        chk("async rst valid", 32'(out_valid_o), 32'd0);
        chk("async rst pc", 32'(pc_o), 32'd0);
        chk("async rst ready", 32'(in_ready_o), 32'd0);
        @(negedge clk_i); rst_i = 1'b0;
        sb.delete(); sb.push_back(32'h11); sb.push_back(32'h22);
        out_ready_i = 1'b1;
        wait_out("rerun first", 20);
        @(negedge clk_i);
        wait_out("rerun second", 20);
        wait_halt("rerun halted", 20);
        chk("rerun pc", 32'(pc_o), 32'd4);

        // ALU table: inputs via IN, result via OUT, flag via branch target
        in_valid_i = 4'b1111;
        out_ready_i = 1'b1;
        for (int v = 0; v < 16; v++) begin
            prog[0] = inp(5'd0, 5'd1); prog[1] = inp(5'd1, 5'd2);
            prog[2] = alu(vt[v].op, 5'd1, 5'd2, 5'd3); prog[3] = outp(5'd3);
            prog[4] = br(vt[v].op, 5'd1, 5'd2, 8'd2); prog[5] = halt_i(); prog[6] = halt_i();
            plen = 7;
            in_data_i = {64'h0, vt[v].b, vt[v].a};
            sb.delete(); sb.push_back(vt[v].res);
            load_and_start();
            wait_out($sformatf("alu%0d out", v), 20);
            wait_halt($sformatf("alu%0d halted", v), 20);
            chk($sformatf("alu%0d flag pc", v), 32'(pc_o), 32'd5 + 32'(vt[v].flag));
            chk($sformatf("alu%0d hex", v), hex_o, vt[v].res);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
